// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl
//
// Instruction-fetch controller between the program counter and instruction
// memory. It fetches one 16-bit word from the address the PC currently
// presents. The word is latched into the instruction register, and
// jump/branch/halt opcodes are decoded into the enable, control and offset
// inputs of the PC. The PC is updated at most once per fetched instruction.
//
// Optional feature macro: IFETCH_TIMEOUT_EN
//   defined   : a fetch that sees no mem_ready for 15 REQ cycles is aborted,
//               replaced by a NOP, and flagged on fetch_err (sticky).
//   undefined : REQ waits forever and fetch_err is tied low.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous reset, active low
//   pc_in       in  16  current PC value
//   mem_rdata   in  16  instruction word from memory
//   mem_ready   in   1  mem_rdata valid for the outstanding request
//   stall       in   1  holds off new fetches while high (ignored in REQ)
//   flag_z      in   1  ALU zero flag for BZ
//   mem_req     out  1  fetch request, high only in REQ
//   mem_addr    out 16  fetch address (= pc_in)
//   ir_out      out 16  instruction register
//   ir_valid    out  1  one-cycle pulse when ir_out is new
//   pc_en       out  1  PC enable
//   pc_ctrl     out  2  PC control (00 hold, 01 +1, 10 absolute, 11 relative)
//   offset_addr out  8  PC offset / page-0 target
//   halted      out  1  sticky, set once a HLT has been fetched
//   fetch_err   out  1  sticky fetch-timeout flag
// ---------------------------------------------------------------------------
module ifetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        stall,
    input  logic        flag_z,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    output logic        pc_en,
    output logic [1:0]  pc_ctrl,
    output logic [7:0]  offset_addr,
    output logic        halted,
    output logic        fetch_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] UPD  = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_BZ  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [1:0]  r_state;
    logic [15:0] r_ir;
    logic        r_ir_valid;
    logic        r_pc_en;
    logic [1:0]  r_pc_ctrl;
    logic [7:0]  r_offset;
    logic        r_halted;

    logic [1:0]  w_dec_ctrl;
    logic [7:0]  w_dec_off;
    logic        w_dec_halt;
    logic        w_abort;

    // Decode straight off the memory bus so the PC controls are registered
    // in the same edge that captures the instruction.
    always_comb begin
        w_dec_ctrl = 2'b01;
        w_dec_off  = 8'h00;
        w_dec_halt = 1'b0;
        case (mem_rdata[15:12])
            OP_JMP: begin
                w_dec_ctrl = 2'b10;
                w_dec_off  = mem_rdata[7:0];
            end
            OP_BZ: begin
                if (flag_z) begin
                    w_dec_ctrl = 2'b11;
                    w_dec_off  = mem_rdata[7:0];
                end
            end
            OP_HLT: begin
                w_dec_ctrl = 2'b00;
                w_dec_halt = 1'b1;
            end
            default: begin
                w_dec_ctrl = 2'b01;
            end
        endcase
    end

`ifdef IFETCH_TIMEOUT_EN
    logic [3:0] r_to_cnt;
    logic       r_fetch_err;

    // The counter is zero on entry to REQ, so reaching 14 without mem_ready
    // means this is the 15th waiting REQ cycle.
    assign w_abort = (r_state == REQ) && !mem_ready && (r_to_cnt == 4'd14);

    // Counts waiting REQ cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt    <= 4'd0;
            r_fetch_err <= 1'b0;
        end else begin
            if ((r_state == REQ) && !mem_ready && !w_abort) begin
                r_to_cnt <= r_to_cnt + 4'd1;
            end else begin
                r_to_cnt <= 4'd0;
            end
            if (w_abort) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign w_abort   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // Main fetch FSM. The PC controls are loaded at the capture edge, so
    // pc_en is only ever high while in UPD. HLT loads pc_ctrl=00 and leaves
    // pc_en low, so the PC never moves again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ir       <= 16'h0000;
            r_ir_valid <= 1'b0;
            r_pc_en    <= 1'b0;
            r_pc_ctrl  <= 2'b00;
            r_offset   <= 8'h00;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!stall) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        r_ir       <= mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_pc_ctrl  <= w_dec_ctrl;
                        r_offset   <= w_dec_off;
                        if (w_dec_halt) begin
                            r_pc_en  <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else begin
                            r_pc_en <= 1'b1;
                            r_state <= UPD;
                        end
                    end else if (w_abort) begin
                        r_ir       <= 16'h0000;
                        r_ir_valid <= 1'b1;
                        r_pc_en    <= 1'b1;
                        r_pc_ctrl  <= 2'b01;
                        r_offset   <= 8'h00;
                        r_state    <= UPD;
                    end
                end
                UPD: begin
                    r_ir_valid <= 1'b0;
                    r_pc_en    <= 1'b0;
                    r_state    <= stall ? IDLE : REQ;
                end
                HALT: begin
                    r_ir_valid <= 1'b0;
                    r_pc_en    <= 1'b0;
                    r_halted   <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = (r_state == REQ);
    assign mem_addr    = pc_in;
    assign ir_out      = r_ir;
    assign ir_valid    = r_ir_valid;
    assign pc_en       = r_pc_en;
    assign pc_ctrl     = r_pc_ctrl;
    assign offset_addr = r_offset;
    assign halted      = r_halted;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifetch_ctrl
//
// Directed bench for ifetch_ctrl. A small PC model and a programmable
// instruction memory (wait states, or no response at all) surround the DUT.
// Expected instruction words are queued as each program is loaded and are
// popped whenever ir_valid pulses.
// ---------------------------------------------------------------------------
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] pcReg;
    logic [15:0] memRdata;
    logic        memReady;
    logic        stall;
    logic        flagZ;
    logic        memReq;
    logic [15:0] memAddr;
    logic [15:0] irOut;
    logic        irValid;
    logic        pcEn;
    logic [1:0]  pcCtrl;
    logic [7:0]  offsetAddr;
    logic        halted;
    logic        fetchErr;

    logic [15:0] imem [0:255];
    int          reqCount;
    int          readyDelay;
    logic        memHold;

    int          vectors;
    int          miscompares;
    logic [15:0] scoreboard [$];

    ifetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pcReg),
        .mem_rdata   (memRdata),
        .mem_ready   (memReady),
        .stall       (stall),
        .flag_z      (flagZ),
        .mem_req     (memReq),
        .mem_addr    (memAddr),
        .ir_out      (irOut),
        .ir_valid    (irValid),
        .pc_en       (pcEn),
        .pc_ctrl     (pcCtrl),
        .offset_addr (offsetAddr),
        .halted      (halted),
        .fetch_err   (fetchErr)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program counter model: hold / +1 / absolute page-0 / relative forward
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcReg <= 16'h0000;
        end else if (pcEn) begin
            case (pcCtrl)
                2'b01:   pcReg <= pcReg + 16'd1;
                2'b10:   pcReg <= {8'h00, offsetAddr};
                2'b11:   pcReg <= pcReg + {8'h00, offsetAddr};
                default: pcReg <= pcReg;
            endcase
        end
    end

    // Memory answers after readyDelay REQ cycles, or never while memHold is set
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            reqCount <= 0;
        end else begin
            reqCount <= memReq ? reqCount + 1 : 0;
        end
    end

    assign memRdata = imem[memAddr[7:0]];
    assign memReady = memReq && !memHold && (reqCount >= readyDelay);

    // Global guard so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Waits for the next request, checks its address, then waits for the
    // ir_valid pulse and checks the captured word and PC controls.
    // expGap < 0 skips the cycles-until-request check.
    task automatic applyStimulus(input string tag, input logic [15:0] expAddr,
                                 input logic [1:0] expCtrl, input logic [7:0] expOff,
                                 input logic expPcEn, input int expGap, input int expWait);
        int          n;
        logic [15:0] expIr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (memReq !== 1'b1 && n < 50);
        checkOutput({tag, "_req"}, 32'(memReq), 32'(1));
        if (expGap >= 0) checkOutput({tag, "_gap"}, 32'(n), 32'(expGap));
        checkOutput({tag, "_addr"}, 32'(memAddr), 32'(expAddr));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (irValid !== 1'b1 && n < 50);
        checkOutput({tag, "_valid"}, 32'(irValid), 32'(1));
        checkOutput({tag, "_wait"}, 32'(n), 32'(expWait));
        expIr = (scoreboard.size() > 0) ? scoreboard.pop_front() : 16'hxxxx;
        checkOutput({tag, "_ir"}, 32'(irOut), 32'(expIr));
        checkOutput({tag, "_ctrl"}, 32'(pcCtrl), 32'(expCtrl));
        checkOutput({tag, "_off"}, 32'(offsetAddr), 32'(expOff));
        checkOutput({tag, "_pcen"}, 32'(pcEn), 32'(expPcEn));
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        stall       = 1'b0;
        flagZ       = 1'b0;
        memHold     = 1'b0;
        readyDelay  = 0;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;

        // ---- reset values ----
        @(negedge clk);
        checkOutput("rst_ir", 32'(irOut), 32'(0));
        checkOutput("rst_valid", 32'(irValid), 32'(0));
        checkOutput("rst_pcen", 32'(pcEn), 32'(0));
        checkOutput("rst_ctrl", 32'(pcCtrl), 32'(0));
        checkOutput("rst_off", 32'(offsetAddr), 32'(0));
        checkOutput("rst_halted", 32'(halted), 32'(0));
        checkOutput("rst_err", 32'(fetchErr), 32'(0));
        checkOutput("rst_req", 32'(memReq), 32'(0));

        // ---- zero-wait sequential fetch, then HLT ----
        for (int i = 0; i < 4; i++) begin
            imem[i] = 16'h1234;
            scoreboard.push_back(16'h1234);
        end
        imem[4] = 16'hF000;
        scoreboard.push_back(16'hF000);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("idle_first_cycle", 32'(memReq), 32'(0));
        for (int i = 0; i < 4; i++) begin
            applyStimulus("seq", 16'(i), 2'b01, 8'h00, 1'b1, 1, 1);
        end
        applyStimulus("hlt", 16'h0004, 2'b00, 8'h00, 1'b0, 1, 1);
        checkOutput("hlt_halted", 32'(halted), 32'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("halt_hold", 32'({memReq, pcEn, irValid, halted}), 32'(4'b0001));
        end
        rst = 1'b0;
        #1;
        checkOutput("halt_rst_halted", 32'(halted), 32'(0));
        checkOutput("halt_rst_req", 32'(memReq), 32'(0));

        // ---- JMP / BZ / stalled wait program ----
        imem[16'h00] = 16'h0001;
        imem[16'h01] = 16'h0002;
        imem[16'h02] = 16'hC040;
        imem[16'h40] = 16'hC010;
        imem[16'h10] = 16'hD005;
        imem[16'h15] = 16'hC010;
        imem[16'h11] = 16'h0007;
        imem[16'h12] = 16'hF000;
        scoreboard.push_back(16'h0001);
        scoreboard.push_back(16'h0002);
        scoreboard.push_back(16'hC040);
        scoreboard.push_back(16'hC010);
        scoreboard.push_back(16'hD005);
        scoreboard.push_back(16'hC010);
        scoreboard.push_back(16'hD005);
        scoreboard.push_back(16'h0007);
        scoreboard.push_back(16'hF000);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("p0", 16'h0000, 2'b01, 8'h00, 1'b1, 1, 1);
        applyStimulus("p1", 16'h0001, 2'b01, 8'h00, 1'b1, 1, 1);
        applyStimulus("jmp", 16'h0002, 2'b10, 8'h40, 1'b1, 1, 1);
        applyStimulus("jmp_tgt", 16'h0040, 2'b10, 8'h10, 1'b1, 1, 1);
        flagZ = 1'b1;
        applyStimulus("bz_taken", 16'h0010, 2'b11, 8'h05, 1'b1, 1, 1);
        applyStimulus("bz_tgt", 16'h0015, 2'b10, 8'h10, 1'b1, 1, 1);
        flagZ = 1'b0;
        applyStimulus("bz_fall", 16'h0010, 2'b01, 8'h00, 1'b1, 1, 1);

        // three wait states, stall pulsed mid-request
        readyDelay = 3;
        @(negedge clk);
        checkOutput("wait_req1", 32'({memReq, memAddr}), 32'({1'b1, 16'h0011}));
        stall = 1'b1;
        @(negedge clk);
        checkOutput("wait_req2", 32'({memReq, memAddr}), 32'({1'b1, 16'h0011}));
        stall = 1'b0;
        @(negedge clk);
        checkOutput("wait_req3", 32'({memReq, memAddr}), 32'({1'b1, 16'h0011}));
        @(negedge clk);
        checkOutput("wait_req4", 32'({memReq, memAddr}), 32'({1'b1, 16'h0011}));
        @(negedge clk);
        checkOutput("wait_valid", 32'(irValid), 32'(1));
        checkOutput("wait_ir", 32'(irOut), 32'(scoreboard.pop_front()));
        checkOutput("wait_pcen", 32'(pcEn), 32'(1));
        stall = 1'b1;
        readyDelay = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_idle", 32'({memReq, pcEn}), 32'(2'b00));
        end
        stall = 1'b0;
        applyStimulus("after_stall", 16'h0012, 2'b00, 8'h00, 1'b0, 1, 1);
        checkOutput("halted2", 32'(halted), 32'(1));

        // ---- reset mid-fetch drops the request ----
        rst = 1'b0;
        imem[16'h00] = 16'hABCD;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_req_before", 32'({memReq, memAddr}), 32'({1'b1, 16'h0000}));
        rst = 1'b0;
        #1;
        checkOutput("midrst_req", 32'(memReq), 32'(0));
        checkOutput("midrst_valid", 32'(irValid), 32'(0));
        checkOutput("midrst_ir", 32'(irOut), 32'(0));

        // ---- memory never answers ----
        memHold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
`ifdef IFETCH_TIMEOUT_EN
        scoreboard.push_back(16'h0000);
        applyStimulus("timeout", 16'h0000, 2'b01, 8'h00, 1'b1, 1, 15);
        checkOutput("timeout_err", 32'(fetchErr), 32'(1));
        memHold = 1'b0;
        imem[16'h01] = 16'h1111;
        scoreboard.push_back(16'h1111);
        applyStimulus("after_timeout", 16'h0001, 2'b01, 8'h00, 1'b1, 1, 1);
        checkOutput("err_sticky", 32'(fetchErr), 32'(1));
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (memReq === 1'b1 && memAddr === 16'h0000 && fetchErr === 1'b0 && irValid === 1'b0) n++;
        end
        checkOutput("no_timeout_req", 32'(n), 32'(100));
        checkOutput("no_timeout_err", 32'(fetchErr), 32'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that drives the program counter. It reads the current `pc_out` address and fetches a 16-bit instruction from instruction memory over a request/ready handshake. It latches the instruction into an instruction register and decodes jump, branch and halt opcodes into the `en_in`/`pc_ctrl`/`offset_addr` controls the PC consumes. It sits between the PC and instruction memory and issues at most one PC update per fetched instruction.

## Interface
- No parameters.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pc_in` input 16: current PC value (PC `pc_out`).
- `mem_rdata` input 16: instruction word from instruction memory.
- `mem_ready` input 1: memory has valid `mem_rdata` for the current request.
- `stall` input 1: holds off new fetches while high.
- `flag_z` input 1: zero flag from the ALU, used by conditional branches.
- `mem_req` output 1: fetch request (combinational, high only in state REQ).
- `mem_addr` output 16: fetch address; always equals `pc_in`.
- `ir_out` output 16: registered instruction word.
- `ir_valid` output 1: one-cycle pulse when `ir_out` is new.
- `pc_en` output 1: drives PC `en_in`.
- `pc_ctrl` output 2: drives PC `pc_ctrl`.
- `offset_addr` output 8: drives PC `offset_addr`.
- `halted` output 1: sticky; high after a HLT is fetched.
- `fetch_err` output 1: sticky timeout flag (see Configuration).

## Operation
- States: IDLE, REQ, UPD, HALT. The reset state is IDLE.
- IDLE: if `stall`=0, go to REQ; otherwise stay in IDLE.
- REQ: `mem_req`=1. On an edge with `mem_ready`=1:
  - latch `mem_rdata` into `ir_out`;
  - set `ir_valid`=1 and `pc_en`=1;
  - load `pc_ctrl` and `offset_addr` from the decode below;
  - go to UPD, or to HALT for HLT.
- UPD: `ir_valid` and `pc_en` are high for this cycle only, and the PC updates on the closing edge. At that edge, clear both; go to REQ if `stall`=0, else IDLE.
- HALT: `halted`=1, `mem_req`=0, `pc_en`=0. Only reset exits this state.
- Decode uses opcode `ir[15:12]`:
  - 4'hC JMP: `pc_ctrl`=2'b10, `offset_addr`=ir[7:0] (absolute jump into page 0).
  - 4'hD BZ: if `flag_z`=1 (sampled at the capture edge), `pc_ctrl`=2'b11 and `offset_addr`=ir[7:0]. If `flag_z`=0, `pc_ctrl`=2'b01 and `offset_addr`=0.
  - 4'hF HLT: `pc_en`=0, `pc_ctrl`=2'b00, `ir_valid` still pulses, next state HALT.
  - All other opcodes: `pc_ctrl`=2'b01, `offset_addr`=0.
- Relative branch offsets are unsigned and relative to the branch instruction's own address. The PC zero-extends the offset, so backward branches are impossible.
- PC arithmetic wraps at 16'hFFFF inside the PC. This block only passes `pc_in` through and applies no masking.
- `stall` is ignored in REQ: an outstanding request always completes.

## Timing
- Reset values: `ir_out`=0, `ir_valid`=0, `pc_en`=0, `pc_ctrl`=2'b00, `offset_addr`=0, `halted`=0, `fetch_err`=0, `mem_req`=0.
- Asserting `rst` mid-fetch drops `mem_req` immediately; any in-flight `mem_rdata` is discarded.
- After reset release: one cycle in IDLE, with first `mem_req` on the 2nd cycle.
- Zero-wait memory (`mem_ready` high in the first REQ cycle) gives a throughput of 2 cycles per instruction (REQ, UPD).
- Each wait cycle adds one cycle in REQ; `mem_addr` is stable throughout because the PC is not enabled.
- The new `pc_in` is visible in the REQ cycle that follows UPD.
- `pc_en` is never high outside UPD, so the PC advances exactly once per instruction.

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - A 4-bit counter runs while in REQ. If `mem_ready` has not been seen after 15 REQ cycles, the fetch aborts.
  - On abort: `ir_out`=16'h0000 (NOP), `ir_valid` pulses, `pc_ctrl`=2'b01 (skip), `fetch_err` sets and stays set until reset, and the FSM goes to UPD.
- `IFETCH_TIMEOUT_EN` undefined:
  - REQ waits indefinitely for `mem_ready`, and `fetch_err` is tied to 0.
- The port list is identical in both builds.

## Test plan
- Reset, then zero-wait memory returning 16'h1234 at addresses 0..3:
  - PC connected, so `mem_addr` sequences 0,1,2,3 on every other cycle.
  - `ir_valid` pulses every 2 cycles and `ir_out`=16'h1234.
- JMP 16'hC040 at address 2: next `mem_addr`=16'h0040, with `pc_ctrl`=2'b10 and `offset_addr`=8'h40 during UPD.
- BZ 16'hD005 at address 16'h0010:
  - with `flag_z`=1, next `mem_addr`=16'h0015;
  - repeated with `flag_z`=0, next `mem_addr`=16'h0011.
- `mem_ready` delayed 3 cycles with `stall` pulsed high during the wait:
  - `mem_req` stays high for 4 cycles with `mem_addr` constant, and the fetch completes;
  - with `stall` then held high, the FSM waits in IDLE with `mem_req`=0.
- HLT 16'hF000:
  - `ir_valid` pulses, `halted`=1, `pc_en` is never asserted, and `mem_req` stays 0 for 20 cycles;
  - `rst` low then high resumes fetching at address 0.
- `IFETCH_TIMEOUT_EN` build with `mem_ready` held low:
  - after 15 REQ cycles, `ir_out`=0, `fetch_err`=1, and the PC advances by 1;
  - non-define build: `mem_req` stays high for 100 cycles and `fetch_err`=0.
